// File: rtl/writeback_stage_if.sv
// MEM-to-WB bundle: instruction fields from the MEM stage and the registerfile write port back out.
interface writeback_stage_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
);
  logic             valid_i;
  logic             flush_i;
  logic             regwrite_i;
  logic [4:0]       rd_i;
  logic [1:0]       wbsel_i;
  logic [2:0]       funct3_i;
  logic [2:0]       addr_lo_i;
  logic [XLEN-1:0]  alu_result_i;
  logic [XLEN-1:0]  load_data_i;
  logic [XLEN-1:0]  pc_i;
  logic             rf_we_o;
  logic [4:0]       rf_a3_o;
  logic [XLEN-1:0]  rf_wd_o;
  logic             misaligned_o;
  logic [CNT_W-1:0] instret_o;

  modport master (
    output valid_i, flush_i, regwrite_i, rd_i, wbsel_i, funct3_i, addr_lo_i,
           alu_result_i, load_data_i, pc_i,
    input  rf_we_o, rf_a3_o, rf_wd_o, misaligned_o, instret_o
  );

  modport slave (
    input  valid_i, flush_i, regwrite_i, rd_i, wbsel_i, funct3_i, addr_lo_i,
           alu_result_i, load_data_i, pc_i,
    output rf_we_o, rf_a3_o, rf_wd_o, misaligned_o, instret_o
  );
endinterface

// File: rtl/writeback_stage.sv
// WB pipeline stage: registers MEM results, aligns/extends load data, drives the
// registerfile write port and counts retired instructions.
module writeback_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
) (
  input logic              clk_i,
  input logic              rst_i,
  writeback_stage_if.slave bus
);

  logic             wb_valid;
  logic             regwrite;
  logic [4:0]       rd;
  logic [1:0]       wbsel;
  logic [2:0]       funct3;
  logic [2:0]       addr_lo;
  logic [XLEN-1:0]  alu_result;
  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  pc;
  logic [CNT_W-1:0] instret;

  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  load_value;
  logic [XLEN-1:0]  wd;
  logic             bad_align;
  logic             misaligned;

  // Fields are captured every cycle; only wb_valid decides whether they mean anything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid   <= 1'b0;
      regwrite   <= 1'b0;
      rd         <= '0;
      wbsel      <= '0;
      funct3     <= '0;
      addr_lo    <= '0;
      alu_result <= '0;
      load_data  <= '0;
      pc         <= '0;
      instret    <= '0;
    end else begin
      wb_valid   <= bus.valid_i & ~bus.flush_i;
      regwrite   <= bus.regwrite_i;
      rd         <= bus.rd_i;
      wbsel      <= bus.wbsel_i;
      funct3     <= bus.funct3_i;
      addr_lo    <= bus.addr_lo_i;
      alu_result <= bus.alu_result_i;
      load_data  <= bus.load_data_i;
      pc         <= bus.pc_i;
      if (wb_valid && !misaligned) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

  always_comb begin
    shifted    = load_data >> {addr_lo, 3'b000};
    load_value = '0;
    case (funct3)
      3'b000:  load_value = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_value = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_value = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b011:  load_value = shifted;
      3'b100:  load_value = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  load_value = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'b110:  load_value = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: load_value = '0;
    endcase
  end

  // Illegal funct3 is folded into the misaligned flag so it is also suppressed.
  always_comb begin
    bad_align = 1'b0;
    case (funct3)
      3'b001, 3'b101: bad_align = addr_lo[0];
      3'b010, 3'b110: bad_align = |addr_lo[1:0];
      3'b011:         bad_align = |addr_lo;
      3'b111:         bad_align = 1'b1;
      default:        bad_align = 1'b0;
    endcase
    misaligned = wb_valid & (wbsel == 2'd1) & bad_align;
  end

  always_comb begin
    wd = alu_result;
    case (wbsel)
      2'd1:    wd = load_value;
      2'd2:    wd = pc + XLEN'(4);
      default: wd = alu_result;
    endcase
  end

  assign bus.rf_we_o      = wb_valid & regwrite & (rd != 5'd0) & ~misaligned;
  assign bus.rf_a3_o      = rd;
  assign bus.rf_wd_o      = wd;
  assign bus.misaligned_o = misaligned;
  assign bus.instret_o    = instret;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected writes are queued as ops are driven
// and popped one cycle later when the stage presents them.
module tb_writeback_stage;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  writeback_stage_if #(.XLEN(64), .CNT_W(64)) wb_if ();
  writeback_stage_if #(.XLEN(64), .CNT_W(2))  small_if ();

  writeback_stage #(.XLEN(64), .CNT_W(64)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (wb_if)
  );

  // Narrow counter instance so wrap-around is reachable in a few cycles.
  writeback_stage #(.XLEN(64), .CNT_W(2)) dut_small (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (small_if)
  );

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [63:0] wd;
    logic        mis;
    logic        chk_wd;
    logic        cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          op_idx = 0;
  logic [63:0] instret_model = '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference load extraction built byte by byte from the raw dcache word.
  function automatic logic [63:0] modelLoad(input logic [2:0] f3, input logic [2:0] off,
                                            input logic [63:0] raw);
    logic [63:0] r;
    int size;
    int o;
    size = 1 << f3[1:0];
    o    = int'(off);
    r    = '0;
    for (int k = 0; k < size; k++) begin
      if (o + k < 8) r[8*k +: 8] = raw[8*(o+k) +: 8];
    end
    if (!f3[2] && size < 8) begin
      for (int b = 8*size; b < 64; b++) r[b] = r[8*size-1];
    end
    return r;
  endfunction

  function automatic logic modelBad(input logic [2:0] f3, input logic [2:0] off);
    int size;
    size = 1 << f3[1:0];
    return (f3 == 3'b111) || ((int'(off) % size) != 0);
  endfunction

  task automatic applyStimulus(input logic vld, input logic fl, input logic rw,
                               input logic [4:0] rd, input logic [1:0] ws,
                               input logic [2:0] f3, input logic [2:0] off,
                               input logic [63:0] alu, input logic [63:0] ld,
                               input logic [63:0] pc);
    exp_t e;
    exp_t got;
    logic v;
    @(negedge clk_i);
    wb_if.valid_i      = vld;
    wb_if.flush_i      = fl;
    wb_if.regwrite_i   = rw;
    wb_if.rd_i         = rd;
    wb_if.wbsel_i      = ws;
    wb_if.funct3_i     = f3;
    wb_if.addr_lo_i    = off;
    wb_if.alu_result_i = alu;
    wb_if.load_data_i  = ld;
    wb_if.pc_i         = pc;
    v        = vld & ~fl;
    e.mis    = v & (ws == 2'd1) & modelBad(f3, off);
    e.we     = v & rw & (rd != 5'd0) & ~e.mis;
    e.a3     = rd;
    e.wd     = (ws == 2'd1) ? modelLoad(f3, off, ld) : (ws == 2'd2) ? pc + 64'd4 : alu;
    e.chk_wd = e.we | (~v & (ws != 2'd1));
    e.cnt    = v & ~e.mis;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    got = sb.pop_front();
    checkOutput($sformatf("op%0d.we", op_idx), {63'd0, wb_if.rf_we_o}, {63'd0, got.we});
    checkOutput($sformatf("op%0d.a3", op_idx), {59'd0, wb_if.rf_a3_o}, {59'd0, got.a3});
    checkOutput($sformatf("op%0d.mis", op_idx), {63'd0, wb_if.misaligned_o}, {63'd0, got.mis});
    checkOutput($sformatf("op%0d.instret", op_idx), wb_if.instret_o, instret_model);
    if (got.chk_wd) checkOutput($sformatf("op%0d.wd", op_idx), wb_if.rf_wd_o, got.wd);
    if (got.cnt) instret_model = instret_model + 64'd1;
    op_idx++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wb_if.valid_i = 0; wb_if.flush_i = 0; wb_if.regwrite_i = 0; wb_if.rd_i = '0;
    wb_if.wbsel_i = '0; wb_if.funct3_i = '0; wb_if.addr_lo_i = '0;
    wb_if.alu_result_i = '0; wb_if.load_data_i = '0; wb_if.pc_i = '0;
    small_if.valid_i = 0; small_if.flush_i = 0; small_if.regwrite_i = 0; small_if.rd_i = '0;
    small_if.wbsel_i = '0; small_if.funct3_i = '0; small_if.addr_lo_i = '0;
    small_if.alu_result_i = '0; small_if.load_data_i = '0; small_if.pc_i = '0;

    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst.we", {63'd0, wb_if.rf_we_o}, 64'd0);
    checkOutput("rst.a3", {59'd0, wb_if.rf_a3_o}, 64'd0);
    checkOutput("rst.wd", wb_if.rf_wd_o, 64'd0);
    checkOutput("rst.mis", {63'd0, wb_if.misaligned_o}, 64'd0);
    checkOutput("rst.instret", wb_if.instret_o, 64'd0);
    checkOutput("rst.small_instret", {62'd0, small_if.instret_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    repeat (5) applyStimulus(0, 0, 0, 5'd0, 2'd0, 3'd0, 3'd0, 64'd0, 64'd0, 64'd0);

    applyStimulus(1, 0, 1, 5'd5, 2'd0, 3'd0, 3'd0, 64'h1234, 64'd0, 64'd0);
    applyStimulus(1, 0, 1, 5'd7, 2'd1, 3'b001, 3'd6, 64'd0, 64'h80FF_0000_0000_0000, 64'd0);
    applyStimulus(1, 0, 1, 5'd8, 2'd1, 3'b101, 3'd6, 64'd0, 64'h80FF_0000_0000_0000, 64'd0);
    applyStimulus(1, 0, 1, 5'd9, 2'd1, 3'b000, 3'd7, 64'd0, 64'h80FF_0000_0000_0000, 64'd0);
    applyStimulus(1, 0, 1, 5'd10, 2'd1, 3'b010, 3'd2, 64'd0, 64'h1122_3344_5566_7788, 64'd0);
    applyStimulus(1, 0, 1, 5'd11, 2'd1, 3'b111, 3'd0, 64'd0, 64'h1122_3344_5566_7788, 64'd0);
    applyStimulus(1, 0, 1, 5'd0, 2'd0, 3'd0, 3'd0, 64'hDEAD, 64'd0, 64'd0);
    applyStimulus(1, 0, 1, 5'd1, 2'd2, 3'd0, 3'd0, 64'd0, 64'd0, 64'h100);
    applyStimulus(1, 0, 1, 5'd12, 2'd1, 3'b011, 3'd0, 64'd0, 64'hCAFE_F00D_1234_5678, 64'd0);
    applyStimulus(1, 0, 1, 5'd13, 2'd2, 3'd0, 3'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC);

    // Back-to-back ops with the middle one flushed.
    applyStimulus(1, 0, 1, 5'd14, 2'd0, 3'd0, 3'd0, 64'hA1, 64'd0, 64'd0);
    applyStimulus(1, 1, 1, 5'd15, 2'd0, 3'd0, 3'd0, 64'hA2, 64'd0, 64'd0);
    applyStimulus(1, 0, 1, 5'd16, 2'd0, 3'd0, 3'd0, 64'hA3, 64'd0, 64'd0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom),
                    2'($urandom), 3'($urandom), 3'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    end
    applyStimulus(0, 0, 0, 5'd0, 2'd0, 3'd0, 3'd0, 64'd0, 64'd0, 64'd0);

    // Reset while a valid op is held: it must vanish without a write or a count.
    applyStimulus(1, 0, 1, 5'd20, 2'd0, 3'd0, 3'd0, 64'h55, 64'd0, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("midrst.we", {63'd0, wb_if.rf_we_o}, 64'd0);
    checkOutput("midrst.a3", {59'd0, wb_if.rf_a3_o}, 64'd0);
    checkOutput("midrst.instret", wb_if.instret_o, 64'd0);
    instret_model = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
    wb_if.valid_i = 1'b0;
    applyStimulus(0, 0, 0, 5'd0, 2'd0, 3'd0, 3'd0, 64'd0, 64'd0, 64'd0);

    // Counter wrap on the 2-bit instance: four retirements bring it back to zero.
    @(negedge clk_i);
    small_if.valid_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    checkOutput("wrap.pre", {62'd0, small_if.instret_o}, 64'd3);
    @(negedge clk_i);
    small_if.valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput("wrap.zero", {62'd0, small_if.instret_o}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
